// File: rtl/fp64sub_seq.sv
// fp64sub_seq: multi-cycle FP64 subtractor, S = A - B.
// Operands are unpacked, aligned, added/subtracted in magnitude form and then
// normalised one bit position per cycle. Truncating, no special-value handling,
// 11-bit wrapping exponent. One operation in flight, valid/ready on both sides.
module fp64sub_seq #(
  parameter int unsigned MAX_NORM_SHIFT = 52
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] A,
  input  logic [63:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] S
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ALIGN  = 3'd1,
    ST_ADDSUB = 3'd2,
    ST_NORM   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [5:0] MAX_CNT = 6'(MAX_NORM_SHIFT);

  state_e      state_q, state_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;     // effective (already inverted) sign of B
  logic [10:0] exp_a_q, exp_a_d;
  logic [10:0] exp_b_q, exp_b_d;
  logic [52:0] man_a_q, man_a_d;
  logic [52:0] man_b_q, man_b_d;
  logic [10:0] sexp_q, sexp_d;
  logic [53:0] sum_q, sum_d;
  logic        sign_q, sign_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] s_q, s_d;

  // Right shift of a 53-bit mantissa; any shift of 53 or more flushes to zero.
  function automatic logic [52:0] shr53(input logic [52:0] m, input logic [10:0] sh);
    logic [52:0] r;
    if (sh >= 11'd53) begin
      r = 53'd0;
    end else begin
      r = m >> sh;
    end
    return r;
  endfunction

  // Next-state and datapath computation for every stage of the operation.
  always_comb begin
    state_d     = state_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    man_a_d     = man_a_q;
    man_b_d     = man_b_q;
    sexp_d      = sexp_q;
    sum_d       = sum_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    s_d         = s_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subnormals use exponent 1 with no hidden bit.
          sign_a_d = A[63];
          sign_b_d = ~B[63];
          exp_a_d  = (A[62:52] == 11'd0) ? 11'd1 : A[62:52];
          exp_b_d  = (B[62:52] == 11'd0) ? 11'd1 : B[62:52];
          man_a_d  = {(A[62:52] != 11'd0), A[51:0]};
          man_b_d  = {(B[62:52] != 11'd0), B[51:0]};
          state_d  = ST_ALIGN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (exp_a_q > exp_b_q) begin
          man_b_d = shr53(man_b_q, exp_a_q - exp_b_q);
          sexp_d  = exp_a_q;
        end else begin
          man_a_d = shr53(man_a_q, exp_b_q - exp_a_q);
          sexp_d  = exp_b_q;
        end
        state_d = ST_ADDSUB;
      end
      ST_ADDSUB: begin
        if (sign_a_q == sign_b_q) begin
          sum_d  = {1'b0, man_a_q} + {1'b0, man_b_q};
          sign_d = sign_a_q;
        end else if (man_a_q > man_b_q) begin
          sum_d  = {1'b0, man_a_q} - {1'b0, man_b_q};
          sign_d = sign_a_q;
        end else begin
          // Equal magnitudes land here, so exact cancellation takes B's sign.
          sum_d  = {1'b0, man_b_q} - {1'b0, man_a_q};
          sign_d = sign_b_q;
        end
        cnt_d   = 6'd0;
        state_d = ST_NORM;
      end
      ST_NORM: begin
        if (sum_q[53]) begin
          sum_d   = sum_q >> 1;
          sexp_d  = sexp_q + 11'd1;
          state_d = ST_DONE;
        end else if (sum_q[52] || (cnt_q == MAX_CNT)) begin
          state_d = ST_DONE;
        end else begin
          sum_d   = sum_q << 1;
          sexp_d  = sexp_q - 11'd1;
          cnt_d   = cnt_q + 6'd1;
          state_d = ST_NORM;
        end
        if (state_d == ST_DONE) begin
          s_d = {sign_q, sexp_d, sum_d[51:0]};
        end else begin
          s_d = s_q;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      exp_a_q     <= 11'd0;
      exp_b_q     <= 11'd0;
      man_a_q     <= 53'd0;
      man_b_q     <= 53'd0;
      sexp_q      <= 11'd0;
      sum_q       <= 54'd0;
      sign_q      <= 1'b0;
      cnt_q       <= 6'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s_q         <= 64'd0;
    end else begin
      state_q     <= state_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      man_a_q     <= man_a_d;
      man_b_q     <= man_b_d;
      sexp_q      <= sexp_d;
      sum_q       <= sum_d;
      sign_q      <= sign_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;

endmodule
